// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry skid, stall/flush.
// Perf counters compiled only when PIPE_STAGE_PERF_EN is defined; otherwise tied to 0.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] CLR_VALUE = '0,
   parameter int unsigned      SKID      = 1,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_stall,
   input  logic             i_flush,
   output logic [1:0]       o_occupancy,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   logic             main_vld_q, main_vld_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic             skid_vld_q, skid_vld_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             acc, xfer_out;

   // With the skid, o_ready depends only on flops and the stall gate, never on i_ready.
   if (SKID != 0) begin : g_rdy_skid
      assign o_ready = ~skid_vld_q & ~i_stall;
   end else begin : g_rdy_single
      assign o_ready = (~main_vld_q | i_ready) & ~i_stall;
   end

   assign acc      = i_valid & o_ready;
   assign xfer_out = main_vld_q & i_ready & ~i_stall;

   always_comb begin
      main_vld_d = main_vld_q;
      main_d     = main_q;
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
      if (i_flush) begin
         main_vld_d = 1'b0;
         main_d     = CLR_VALUE;
         skid_vld_d = 1'b0;
      end else if (SKID != 0) begin
         if (xfer_out) begin
            // Skid is always younger than main, so it refills main first.
            if (skid_vld_q) begin
               main_d     = skid_q;
               skid_vld_d = 1'b0;
            end else if (acc) begin
               main_d = i_data;
            end else begin
               main_vld_d = 1'b0;
            end
         end else if (acc) begin
            if (main_vld_q) begin
               skid_d     = i_data;
               skid_vld_d = 1'b1;
            end else begin
               main_d     = i_data;
               main_vld_d = 1'b1;
            end
         end
      end else begin
         if (acc) begin
            main_d     = i_data;
            main_vld_d = 1'b1;
         end else if (xfer_out) begin
            main_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         main_vld_q <= 1'b0;
         main_q     <= CLR_VALUE;
         skid_vld_q <= 1'b0;
         skid_q     <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         main_q     <= main_d;
         skid_vld_q <= skid_vld_d;
         skid_q     <= skid_d;
      end
   end

   assign o_valid     = main_vld_q;
   assign o_data      = main_q;
   assign o_occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating counters: they stop at all-ones rather than wrap.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (main_vld_q && !(i_ready && !i_stall) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (i_flush && (o_occupancy != 2'd0) && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance (main) plus a SKID=0 instance.
module tb_pipe_stage_reg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 4;
   localparam logic [WIDTH-1:0] CLR = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid, ready, stall, flush;
   logic [WIDTH-1:0] din;

   logic             rdy1, vld1, rdy0, vld0;
   logic [WIDTH-1:0] dout1, dout0;
   logic [1:0]       occ1, occ0;
   logic [CNT_W-1:0] scnt1, fcnt1, scnt0, fcnt0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(WIDTH), .CLR_VALUE(CLR), .SKID(1), .CNT_W(CNT_W)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy1), .i_data(din),
      .o_valid(vld1), .i_ready(ready), .o_data(dout1), .i_stall(stall), .i_flush(flush),
      .o_occupancy(occ1), .o_stall_cnt(scnt1), .o_flush_cnt(fcnt1)
   );

   pipe_stage_reg #(.WIDTH(WIDTH), .CLR_VALUE(CLR), .SKID(0), .CNT_W(CNT_W)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy0), .i_data(din),
      .o_valid(vld0), .i_ready(ready), .o_data(dout0), .i_stall(stall), .i_flush(flush),
      .o_occupancy(occ0), .o_stall_cnt(scnt0), .o_flush_cnt(fcnt0)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected perf-counter value: the counters read 0 when they are not built.
   function automatic logic [63:0] pc(input int v);
`ifdef PIPE_STAGE_PERF_EN
      return 64'(v);
`else
      return 64'(v - v);
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 1'b0; ready = 1'b0; stall = 1'b0; flush = 1'b0; din = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Fill the SKID=1 stage to two entries (d1 in main, d2 in skid).
   task automatic fill2(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
      ready = 1'b0; valid = 1'b1; din = d1;
      tick();
      din = d2;
      tick();
      valid = 1'b0;
      #1;
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_valid", vld1, 0);
      chk("rst_data", dout1, CLR);
      chk("rst_occ", occ1, 0);
      chk("rst_ready", rdy1, 1);
      chk("rst_scnt", scnt1, 0);

      // 1 streaming
      ready = 1'b1; valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         din = WIDTH'(i);
         tick();
         chk("stream_valid", vld1, 1);
         chk("stream_data", dout1, i);
         chk("stream_occ", occ1, 1);
      end
      chk("stream_scnt", scnt1, 0);

      // 2 backpressure
      do_reset();
      fill2(32'hA, 32'hB);
      chk("bp_occ2", occ1, 2);
      chk("bp_ready", rdy1, 0);
      chk("bp_dataA", dout1, 32'hA);
      chk("bp_scnt", scnt1, pc(1));
      ready = 1'b1;
      #1;
      chk("bp_ready_still0", rdy1, 0);
      tick();
      chk("bp_dataB", dout1, 32'hB);
      chk("bp_validB", vld1, 1);
      chk("bp_occ1", occ1, 1);
      chk("bp_ready_back", rdy1, 1);
      tick();
      chk("bp_drained", vld1, 0);
      chk("bp_occ0", occ1, 0);

      // 3 stall
      do_reset();
      ready = 1'b1; valid = 1'b1; din = 32'hCAFE;
      tick();
      valid = 1'b0; stall = 1'b1;
      #1;
      chk("st_ready", rdy1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_data", dout1, 32'hCAFE);
         chk("st_valid", vld1, 1);
      end
      chk("st_scnt", scnt1, pc(3));
      stall = 1'b0;
      tick();
      chk("st_emitted", vld1, 0);

      // 4 flush beats stall and accept
      do_reset();
      fill2(32'h1, 32'h2);
      flush = 1'b1; stall = 1'b1; valid = 1'b1; din = 32'h3;
      tick();
      chk("fl_valid", vld1, 0);
      chk("fl_data", dout1, CLR);
      chk("fl_occ", occ1, 0);
      chk("fl_fcnt", fcnt1, pc(1));
      flush = 1'b0; stall = 1'b0; valid = 1'b0;
      tick();
      chk("fl_lost", vld1, 0);
      chk("fl_ready", rdy1, 1);

      // 5 asynchronous reset mid-operation
      do_reset();
      fill2(32'h5, 32'h6);
      chk("ar_pre_occ", occ1, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", vld1, 0);
      chk("ar_data", dout1, CLR);
      chk("ar_occ", occ1, 0);
      chk("ar_scnt", scnt1, 0);
      ready = 1'b1;
      tick();
      chk("ar_hold_valid", vld1, 0);
      #2 rst_n = 1'b1;
      #1;
      chk("ar_ready", rdy1, 1);

      // 6 counter saturation
      do_reset();
      ready = 1'b0; valid = 1'b1; din = 32'h77;
      tick();
      valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 10) chk("sat_scnt10", scnt1, pc(10));
      end
      chk("sat_scnt20", scnt1, pc(15));
      tick();
      chk("sat_scnt_hold", scnt1, pc(15));

      // 7 single-register variant
      do_reset();
      ready = 1'b1; valid = 1'b1; din = 32'h11;
      tick();
      chk("s0_valid", vld0, 1);
      chk("s0_data", dout0, 32'h11);
      ready = 1'b0; din = 32'h22;
      #1;
      chk("s0_ready_low", rdy0, 0);
      tick();
      chk("s0_hold", dout0, 32'h11);
      ready = 1'b1;
      #1;
      chk("s0_ready_comb", rdy0, 1);
      tick();
      chk("s0_data2", dout0, 32'h22);
      chk("s0_occ", occ0, 1);
      valid = 1'b0;
      tick();
      chk("s0_empty", vld0, 0);
      chk("s0_occ0", occ0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
